pc_sequencer: RTL and testbench

Program-counter sequencer for the 6502 core: drives the DATA inputs and bus-enable lines of the PCL and PCH registers and sequences the multi-cycle program-counter operations: increment, absolute jump, relative branch with page-cross fix-up, and push to stack. It sits between the instruction decoder (command side) and the PCL/PCH register pair (datapath side). Those registers capture DATA on every CLK rising edge and return their contents on their LOOP outputs.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_adder.sv | 40 ++++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_seq_pkg                                                |
// | Purpose  : Shared command codes, FSM state encoding and the default  |
// |            reset vector for the program-counter sequencer.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pc_seq_pkg;

  // Decoder command codes; 5..7 are not listed and behave as NOP.
  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_INC    = 3'd1;
  localparam logic [2:0] CMD_JMP    = 3'd2;
  localparam logic [2:0] CMD_BRANCH = 3'd3;
  localparam logic [2:0] CMD_PUSH   = 3'd4;

  // Value loaded into PCH:PCL while reset is held.
  localparam logic [15:0] DEFAULT_RESET_PC = 16'hFFFC;

  // Binary-encoded sequencer states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_JMP_LO = 3'd1,
    S_JMP_HI = 3'd2,
    S_BR_FIX = 3'd3,
    S_PUSH_H = 3'd4,
    S_PUSH_L = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_sequencer_if                                           |
// | Purpose  : Command handshake plus PCL/PCH datapath connections of    |
// |            the program-counter sequencer.                            |
// |   master : decoder/datapath side (drives cmd, db_in, *_loop)         |
// |   slave  : sequencer side (drives cmd_ready, *_data, bus enables)    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface pc_sequencer_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic [7:0] db_in;
  logic [7:0] pcl_loop;
  logic [7:0] pch_loop;
  logic [7:0] pcl_data;
  logic [7:0] pch_data;
  logic       pcl_db_en;
  logic       pcl_adl_en;
  logic       pch_db_en;
  logic       pch_adh_en;

  modport master (
    output cmd_valid, cmd, db_in, pcl_loop, pch_loop,
    input  cmd_ready, pcl_data, pch_data,
           pcl_db_en, pcl_adl_en, pch_db_en, pch_adh_en
  );

  modport slave (
    input  cmd_valid, cmd, db_in, pcl_loop, pch_loop,
    output cmd_ready, pcl_data, pch_data,
           pcl_db_en, pcl_adl_en, pch_db_en, pch_adh_en
  );
endinterface
`default_nettype wire

// File: rtl/pc_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_adder                                                  |
// | Purpose  : Combinational PC arithmetic.                              |
// |   i_pc          : current PCH:PCL                                    |
// |   i_offset      : signed branch offset                               |
// |   i_fix_dec     : page fix-up direction (1 = decrement PCH)          |
// |   o_inc         : PC + 1 (16-bit wrap)                               |
// |   o_br_pcl      : PCL + offset (8-bit)                               |
// |   o_page_cross  : branch target lies in another page                 |
// |   o_dir_dec     : fix-up direction implied by the offset sign        |
// |   o_pch_fix     : PCH +/- 1 according to i_fix_dec                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pc_adder (
  input  wire logic [15:0] i_pc,
  input  wire logic [7:0]  i_offset,
  input  wire logic        i_fix_dec,
  output logic      [15:0] o_inc,
  output logic      [7:0]  o_br_pcl,
  output logic             o_page_cross,
  output logic             o_dir_dec,
  output logic      [7:0]  o_pch_fix
);

  logic [8:0] w_lo_sum;

  assign o_inc    = i_pc + 16'd1;
  assign w_lo_sum = {1'b0, i_pc[7:0]} + {1'b0, i_offset};
  assign o_br_pcl = w_lo_sum[7:0];

  // A forward offset crosses on carry-out; a backward offset (two's
  // complement) crosses when there is no carry-out.
  assign o_page_cross = w_lo_sum[8] ^ i_offset[7];
  assign o_dir_dec    = i_offset[7];

  assign o_pch_fix = i_fix_dec ? (i_pc[15:8] - 8'd1) : (i_pc[15:8] + 8'd1);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_sequencer                                              |
// | Purpose  : Sequences increment, absolute jump, relative branch with  |
// |            page-cross fix-up and stack push for the PCL/PCH pair.    |
// |   clk    : system clock, rising edge                                 |
// |   rst    : asynchronous active-high reset                            |
// |   bus    : command handshake and PCL/PCH datapath (slave modport)    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pc_sequencer_if.slave    bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_tmp_lo;
  logic [7:0] w_tmp_lo_nxt;
  logic       r_dir_dec;
  logic       w_dir_dec_nxt;

  logic [15:0] w_inc;
  logic [7:0]  w_br_pcl;
  logic        w_page_cross;
  logic        w_dir_dec;
  logic [7:0]  w_pch_fix;

  pc_adder u_adder (
    .i_pc         ({bus.pch_loop, bus.pcl_loop}),
    .i_offset     (bus.db_in),
    .i_fix_dec    (r_dir_dec),
    .o_inc        (w_inc),
    .o_br_pcl     (w_br_pcl),
    .o_page_cross (w_page_cross),
    .o_dir_dec    (w_dir_dec),
    .o_pch_fix    (w_pch_fix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tmp_lo  <= 8'd0;
      r_dir_dec <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmp_lo  <= w_tmp_lo_nxt;
      r_dir_dec <= w_dir_dec_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tmp_lo_nxt   = r_tmp_lo;
    w_dir_dec_nxt  = r_dir_dec;
    bus.cmd_ready  = 1'b0;
    bus.pcl_db_en  = 1'b0;
    bus.pcl_adl_en = 1'b0;
    bus.pch_db_en  = 1'b0;
    bus.pch_adh_en = 1'b0;
    bus.pcl_data   = bus.pcl_loop;
    bus.pch_data   = bus.pch_loop;

    // Reset overrides the outputs combinationally so an in-flight load is
    // abandoned in the same cycle reset rises.
    if (rst) begin
      bus.pcl_data = RESET_PC[7:0];
      bus.pch_data = RESET_PC[15:8];
      w_state_nxt  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          bus.cmd_ready  = 1'b1;
          bus.pcl_adl_en = 1'b1;
          bus.pch_adh_en = 1'b1;
          if (bus.cmd_valid) begin
            case (bus.cmd)
              CMD_INC: begin
                bus.pcl_data = w_inc[7:0];
                bus.pch_data = w_inc[15:8];
              end
              CMD_JMP:  w_state_nxt = S_JMP_LO;
              CMD_BRANCH: begin
                bus.pcl_data = w_br_pcl;
                if (w_page_cross) begin
                  w_dir_dec_nxt = w_dir_dec;
                  w_state_nxt   = S_BR_FIX;
                end
              end
              CMD_PUSH: w_state_nxt = S_PUSH_H;
              default:  ;
            endcase
          end
        end
        S_JMP_LO: begin
          w_tmp_lo_nxt = bus.db_in;
          w_state_nxt  = S_JMP_HI;
        end
        S_JMP_HI: begin
          bus.pcl_data = r_tmp_lo;
          bus.pch_data = bus.db_in;
          w_state_nxt  = S_IDLE;
        end
        S_BR_FIX: begin
          bus.pch_data = w_pch_fix;
          w_state_nxt  = S_IDLE;
        end
        S_PUSH_H: begin
          bus.pch_db_en = 1'b1;
          w_state_nxt   = S_PUSH_L;
        end
        S_PUSH_L: begin
          bus.pcl_db_en = 1'b1;
          w_state_nxt   = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pc_sequencer                                           |
// | Purpose  : Self-checking bench for pc_sequencer with a PC-level      |
// |            reference model and a behavioural PCL/PCH register pair.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PCL/PCH registers: capture DATA every rising edge, return it on LOOP.
  logic [7:0] r_pcl;
  logic [7:0] r_pch;
  always_ff @(posedge clk) begin
    r_pcl <= bus.pcl_data;
    r_pch <= bus.pch_data;
  end
  assign bus.pcl_loop = r_pcl;
  assign bus.pch_loop = r_pch;

  // {cmd_ready, pcl_adl_en, pch_adh_en, pcl_db_en, pch_db_en}
  logic [4:0]  ctl;
  logic [15:0] pc_now;
  assign ctl    = {bus.cmd_ready, bus.pcl_adl_en, bus.pch_adh_en, bus.pcl_db_en, bus.pch_db_en};
  assign pc_now = {bus.pch_loop, bus.pcl_loop};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] pc_model;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered at a falling edge with the sequencer idle; returns at a later
  // falling edge with the sequencer idle again and the PC updated.
  task automatic run_cmd(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] tgt;
    logic [4:0]  exp_ctl;
    int          busy;
    tgt  = pc_model;
    busy = 0;
    case (c)
      CMD_INC:    tgt = pc_model + 16'd1;
      CMD_JMP:    begin tgt = {b, a}; busy = 2; end
      CMD_BRANCH: begin
        tgt  = pc_model + {{8{a[7]}}, a};
        busy = (tgt[15:8] != pc_model[15:8]) ? 1 : 0;
      end
      CMD_PUSH:   busy = 2;
      default:    tgt = pc_model;
    endcase

    check("idle_ctl", {11'd0, ctl}, 16'h001C);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.db_in     = (c == CMD_BRANCH) ? a : 8'($urandom);
    #1;
    if (c == CMD_BRANCH) check("br_pcl_data", {8'd0, bus.pcl_data}, {8'd0, tgt[7:0]});

    for (int k = 0; k < busy; k++) begin
      @(negedge clk);
      // Commands offered while busy must be dropped.
      bus.cmd_valid = 1'b1;
      bus.cmd       = 3'($urandom);
      bus.db_in     = 8'($urandom);
      if (c == CMD_JMP) bus.db_in = (k == 0) ? a : b;
      #1;
      exp_ctl = 5'b00000;
      if (c == CMD_PUSH) exp_ctl = (k == 0) ? 5'b00001 : 5'b00010;
      check("busy_ctl", {11'd0, ctl}, {11'd0, exp_ctl});
      if (c == CMD_PUSH)
        check("push_bus", {8'd0, (k == 0) ? bus.pch_loop : bus.pcl_loop},
              {8'd0, (k == 0) ? pc_model[15:8] : pc_model[7:0]});
      if (c == CMD_JMP && k == 1)
        check("jmp_data", {bus.pch_data, bus.pcl_data}, tgt);
      if (c == CMD_BRANCH)
        check("br_mid_pc", pc_now, {pc_model[15:8], tgt[7:0]});
    end

    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    #1;
    pc_model = tgt;
    check("pc", pc_now, pc_model);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    bus.db_in     = 8'd0;
    rst           = 1'b1;

    // Reset held for two edges.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {11'd0, ctl}, 16'h0000);
    check("rst_data", {bus.pch_data, bus.pcl_data}, 16'hFFFC);
    check("rst_pc", pc_now, 16'hFFFC);
    rst = 1'b0;
    #1;
    check("rel_ctl", {11'd0, ctl}, 16'h001C);
    pc_model = 16'hFFFC;

    // Increment carry and wrap.
    run_cmd(CMD_JMP, 8'hFF, 8'h00);
    run_cmd(CMD_INC, 8'h00, 8'h00);
    check("inc_carry", pc_now, 16'h0100);
    run_cmd(CMD_JMP, 8'hFF, 8'hFF);
    run_cmd(CMD_INC, 8'h00, 8'h00);
    check("inc_wrap", pc_now, 16'h0000);

    // Jump.
    run_cmd(CMD_JMP, 8'h34, 8'h12);
    check("jmp_1234", pc_now, 16'h1234);

    // Branches: same page, forward cross, backward cross.
    run_cmd(CMD_JMP, 8'hF0, 8'h10);
    run_cmd(CMD_BRANCH, 8'h05, 8'h00);
    check("br_same", pc_now, 16'h10F5);
    run_cmd(CMD_JMP, 8'hFE, 8'h10);
    run_cmd(CMD_BRANCH, 8'h04, 8'h00);
    check("br_fwd", pc_now, 16'h1102);
    run_cmd(CMD_JMP, 8'h02, 8'h10);
    run_cmd(CMD_BRANCH, 8'hFC, 8'h00);
    check("br_back", pc_now, 16'h0FFE);

    // Push leaves the PC untouched.
    run_cmd(CMD_JMP, 8'hCD, 8'hAB);
    run_cmd(CMD_PUSH, 8'h00, 8'h00);
    check("push_pc", pc_now, 16'hABCD);

    // Undefined code behaves as NOP.
    run_cmd(3'd6, 8'h00, 8'h00);

    // Randomized command stream.
    for (int i = 0; i < 300; i++)
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

    // Reset during JMP_HI.
    bus.cmd_valid = 1'b1;
    bus.cmd       = CMD_JMP;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.db_in     = 8'h99;
    @(negedge clk);
    bus.db_in     = 8'h56;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_data", {bus.pch_data, bus.pcl_data}, 16'hFFFC);
    check("mid_rst_ctl", {11'd0, ctl}, 16'h0000);
    @(negedge clk);
    check("mid_rst_pc", pc_now, 16'hFFFC);
    rst = 1'b0;
    #1;
    check("mid_rel_ctl", {11'd0, ctl}, 16'h001C);
    pc_model = 16'hFFFC;
    run_cmd(CMD_INC, 8'h00, 8'h00);
    check("post_rst_inc", pc_now, 16'hFFFD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
